serial_accumulator_64: RTL and testbench
========================================

SERIAL_ACCUMULATOR_64 -- requirements
Module: serial_accumulator_64

Interface
REQ-001 The block SHALL have no parameters; widths are fixed at a 64-bit accumulator processed as four 16-bit slices.
REQ-002 The block SHALL use one clock and an asynchronous, active-low reset, with these ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand word present.
- in_ready  out  1  block can accept an operand; high exactly when the FSM is in IDLE.
- in_data  in  64  operand to add into the accumulator.
- in_clear  in  1  sampled with the operand; when high, the add uses a zeroed accumulator.
- out_valid  out  1  accumulator result available.
- out_ready  in  1  consumer accepts the result.
- acc_out  out  64  accumulator value.
- overflow  out  1  sticky unsigned carry-out of bit 63.

Function
REQ-003 The FSM SHALL have states IDLE, ADD and DONE, with a 2-bit slice index k used in ADD.
REQ-004 IDLE: on in_valid & in_ready at a rising edge, the block SHALL latch in_data and in_clear, set k=0 and carry=0, and enter ADD.
- If in_clear=1, the accumulator and overflow SHALL be zeroed on that same edge.
REQ-005 ADD: each cycle, the block SHALL compute slice k as acc[16k+15:16k] + opnd[16k+15:16k] + carry.
- The 16-bit sum SHALL be written back to slice k, and the slice carry-out SHALL be registered as carry.
- k SHALL increment each cycle; after k=3 the FSM SHALL enter DONE.
REQ-006 Slice 0 SHALL always use carry-in 0, and there SHALL be exactly one 16-bit adder instance, shared across beats.
REQ-007 The carry-out of slice 3 SHALL set overflow (sticky); only in_clear or reset clears it.
REQ-008 Latency: with the operand accepted at edge E0, slices SHALL be written at E1..E4, and out_valid SHALL be high from E4 until the output handshake.
REQ-009 DONE: out_valid=1 and acc_out stable; on out_valid & out_ready the FSM SHALL return to IDLE at that edge.
REQ-010 in_ready SHALL be 0 in ADD and DONE, so a new operand is never accepted while a result is pending.
REQ-011 acc_out SHALL always reflect the accumulator register; its value SHALL be defined as a result only while out_valid=1.
REQ-012 Arithmetic SHALL be unsigned modulo 2^64 (wrap-around) unless SATURATE_EN is defined.

Reset
REQ-013 While rst_n=0, the block SHALL hold: state=IDLE, k=0, carry=0, acc=0, overflow=0, out_valid=0, in_ready=1.
REQ-014 A reset asserted mid-ADD or in DONE SHALL abort the operation immediately, with no partial result retained.
REQ-015 The first handshake SHALL be accepted on the first rising edge after rst_n rises.

Configuration
REQ-016 Macro SATURATE_EN SHALL select overflow behaviour:
- Defined: when the slice-3 carry-out is 1, acc SHALL be forced to 64'hFFFF_FFFF_FFFF_FFFF at E4 (overflow also set). Once saturated, acc SHALL stay saturated until in_clear.
- Undefined: acc wraps modulo 2^64.

Structure
REQ-017 A shared package SHALL hold:
- the FSM state enum (IDLE/ADD/DONE);
- constants SLICE_W=16, NUM_SLICES=4, ACC_W=64.
REQ-018 One sub-module, slice_adder16, SHALL implement a purely combinational 16-bit adder (A, B, Cin -> Sum, Cout) with sum bit = a^b^c and carry = ab | c(a^b).

Verification
REQ-019 Reset then add 64'h1 with in_clear=1 -> out_valid at E4, acc_out=64'h1, overflow=0.
REQ-020 With acc=64'h0000_0000_0000_FFFF, add 64'h1 (clear=0) -> acc_out=64'h0000_0000_0001_0000, carry propagates from slice 0 to slice 1.
REQ-021 With acc=64'hFFFF_FFFF_FFFF_FFFF, add 64'h2:
- without SATURATE_EN -> acc_out=64'h1, overflow=1;
- with SATURATE_EN -> acc_out all-ones, overflow=1.
REQ-022 Hold out_ready=0 for 5 cycles in DONE with in_valid=1 -> in_ready stays 0, acc_out stable. When out_ready=1, return to IDLE and accept the next operand the following cycle.
REQ-023 Assert rst_n=0 at E2 of an add -> next cycle acc_out=0, out_valid=0, in_ready=1, state IDLE.
REQ-024 Back-to-back adds of 64'h8000_0000_0000_0000 twice (first with clear) -> acc_out=0, overflow=1. A third add with clear -> overflow=0.

Source files
------------

// File: rtl/serial_accumulator_64_pkg.sv
// Shared definitions for the 64-bit slice-serial accumulator:
// FSM state encoding and the fixed slice geometry.
package serial_accumulator_64_pkg;

  localparam int SLICE_W    = 16;
  localparam int NUM_SLICES = 4;
  localparam int ACC_W      = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_accumulator_64_slice_adder16.sv
// Combinational 16-bit ripple-carry adder used once per beat by the
// serial accumulator. Each bit is a full adder: sum = a^b^c,
// carry = ab | c(a^b).
module slice_adder16
  import serial_accumulator_64_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] sum,
  output logic               cout
);

  logic [SLICE_W:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < SLICE_W; i++) begin : g_bit
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[SLICE_W];

endmodule

// File: rtl/serial_accumulator_64.sv
// 64-bit accumulator that adds one operand as four 16-bit beats through a
// single shared slice adder. Accept at E0, slices written E1..E4, result
// held with out_valid until the consumer takes it.
// Optional build macro: SATURATE_EN -- when defined, a carry out of the top
// slice clamps the accumulator to all-ones instead of wrapping.
module serial_accumulator_64
  import serial_accumulator_64_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [ACC_W-1:0] in_data,
  input  logic             in_clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             overflow
);

  state_t             state;
  state_t             state_next;
  logic [1:0]         k;
  logic               carry;
  logic               ovf;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   opnd;

  logic               accept;
  logic               last_beat;
  logic               cin;
  logic               cout;
  logic [SLICE_W-1:0] a_slice;
  logic [SLICE_W-1:0] b_slice;
  logic [SLICE_W-1:0] sum;
  logic [ACC_W-1:0]   acc_written;
  logic [ACC_W-1:0]   acc_update;

  // Replace slice idx of word with s.
  function automatic logic [ACC_W-1:0] insert_slice(
    input logic [ACC_W-1:0]   word,
    input logic [1:0]         idx,
    input logic [SLICE_W-1:0] s
  );
    logic [ACC_W-1:0] r;
    r = word;
    r[{idx, 4'b0000} +: SLICE_W] = s;
    return r;
  endfunction

`ifdef SATURATE_EN
  // Clamp to all-ones when the final beat carries out of bit 63.
  function automatic logic [ACC_W-1:0] saturate(
    input logic [ACC_W-1:0] val,
    input logic             top_carry
  );
    return top_carry ? {ACC_W{1'b1}} : val;
  endfunction
`endif

  assign accept    = in_valid & (state == IDLE);
  assign last_beat = (k == 2'd3);

  // Beat datapath: slice k of accumulator and operand through the one adder.
  // The low slice never takes a carry in, independent of the carry register.
  assign a_slice = acc[{k, 4'b0000} +: SLICE_W];
  assign b_slice = opnd[{k, 4'b0000} +: SLICE_W];
  assign cin     = (k == 2'd0) ? 1'b0 : carry;

  slice_adder16 u_slice_adder (
    .a   (a_slice),
    .b   (b_slice),
    .cin (cin),
    .sum (sum),
    .cout(cout)
  );

  assign acc_written = insert_slice(acc, k, sum);
`ifdef SATURATE_EN
  assign acc_update  = saturate(acc_written, last_beat & cout);
`else
  assign acc_update  = acc_written;
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // FSM next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid)  state_next = ADD;
      ADD:     if (last_beat) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  // FSM outputs: handshake flags decode directly from the state.
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // Operand capture; data only, its value matters just during ADD.
  always_ff @(posedge clk) begin
    if (accept) opnd <= in_data;
  end

  // Accumulator, beat index, inter-slice carry and sticky overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      ovf   <= 1'b0;
      k     <= 2'd0;
      carry <= 1'b0;
    end else begin
      if (accept) begin
        k     <= 2'd0;
        carry <= 1'b0;
        if (in_clear) begin
          acc <= '0;
          ovf <= 1'b0;
        end
      end else if (state == ADD) begin
        acc   <= acc_update;
        carry <= cout;
        k     <= k + 2'd1;
        if (last_beat && cout) ovf <= 1'b1;
      end
    end
  end

  assign acc_out  = acc;
  assign overflow = ovf;

endmodule

// File: tb/tb_serial_accumulator_64.sv
// Self-checking bench for serial_accumulator_64: directed corner cases plus
// randomized adds, scored against a whole-word arithmetic reference model.
module tb_serial_accumulator_64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        in_clear;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] acc_out;
  logic        overflow;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [63:0] acc;
    logic        ovf;
  } exp_t;

  exp_t        sb_q[$];
  logic [63:0] m_acc = '0;
  logic        m_ovf = 1'b0;

  serial_accumulator_64 dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_clear (in_clear),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .acc_out  (acc_out),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: full 65-bit sum of accumulator and operand.
  task automatic model_push(input logic [63:0] data, input logic clear);
    logic [64:0] full;
    exp_t        e;
    if (clear) begin
      m_acc = '0;
      m_ovf = 1'b0;
    end
    full = {1'b0, m_acc} + {1'b0, data};
    if (full[64]) m_ovf = 1'b1;
`ifdef SATURATE_EN
    m_acc = full[64] ? 64'hFFFF_FFFF_FFFF_FFFF : full[63:0];
`else
    m_acc = full[63:0];
`endif
    e.acc = m_acc;
    e.ovf = m_ovf;
    sb_q.push_back(e);
  endtask

  // Monitor: score each result at the cycle its handshake completes.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check("sb_unexpected_result", 64'd1, 64'd0);
        end else begin
          e = sb_q.pop_front();
          check("sb_acc", acc_out, e.acc);
          check("sb_overflow", {63'b0, overflow}, {63'b0, e.ovf});
        end
      end
    end
  end

  // Issue one add; stall cycles in DONE with out_ready low and in_valid high.
  task automatic do_add(input logic [63:0] data, input logic clear, input int stall);
    int          cyc;
    logic [63:0] held;
    cyc = 0;
    while (!in_ready && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (!in_ready) check("wait_in_ready", 64'd0, 64'd1);
    in_valid = 1'b1;
    in_data  = data;
    in_clear = clear;
    model_push(data, clear);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_clear = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 10) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("latency", 64'(cyc), 64'd4);
    held = acc_out;
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'b1;
      in_data  = {$urandom(), $urandom()};
      check("stall_in_ready", {63'b0, in_ready}, 64'd0);
      check("stall_acc_stable", acc_out, held);
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("idle_after_hs", {63'b0, in_ready}, 64'd1);
  endtask

  task automatic expect_state(input string name, input logic [63:0] a, input logic o);
    check({name, "_acc"}, acc_out, a);
    check({name, "_ovf"}, {63'b0, overflow}, {63'b0, o});
  endtask

  // Watchdog against a stuck run.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // Stimulus.
  initial begin
    logic [63:0] d;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_clear  = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_acc", acc_out, 64'd0);
    check("rst_ovf", {63'b0, overflow}, 64'd0);
    check("rst_out_valid", {63'b0, out_valid}, 64'd0);
    check("rst_in_ready", {63'b0, in_ready}, 64'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Accepted on first rising edge after reset release.
    do_add(64'h1, 1'b1, 0);
    expect_state("add_one", 64'h1, 1'b0);

    do_add(64'h0000_0000_0000_FFFF, 1'b1, 0);
    do_add(64'h1, 1'b0, 0);
    expect_state("carry_s0_s1", 64'h0000_0000_0001_0000, 1'b0);

    do_add(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 0);
    do_add(64'h2, 1'b0, 0);
`ifdef SATURATE_EN
    expect_state("top_carry", 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
`else
    expect_state("top_carry", 64'h1, 1'b1);
`endif

    do_add(64'h0000_1234_0000_5678, 1'b1, 5);
    expect_state("stall_result", 64'h0000_1234_0000_5678, 1'b0);

    // Reset during the second beat of an add.
    in_valid = 1'b1;
    in_data  = 64'h0123_4567_89AB_CDEF;
    in_clear = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_clear = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("abort_acc", acc_out, 64'd0);
    check("abort_out_valid", {63'b0, out_valid}, 64'd0);
    check("abort_in_ready", {63'b0, in_ready}, 64'd1);
    check("abort_ovf", {63'b0, overflow}, 64'd0);
    m_acc = '0;
    m_ovf = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    do_add(64'h8000_0000_0000_0000, 1'b1, 0);
    do_add(64'h8000_0000_0000_0000, 1'b0, 0);
`ifdef SATURATE_EN
    expect_state("msb_twice", 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
`else
    expect_state("msb_twice", 64'h0, 1'b1);
`endif
    do_add(64'h7, 1'b1, 0);
    expect_state("clear_ovf", 64'h7, 1'b0);

    // Randomized adds with a mix of carry-heavy operands.
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 3))
        0:       d = {$urandom(), $urandom()};
        1:       d = 64'($urandom_range(0, 70000));
        2:       d = {16'hFFFF, 16'($urandom()), 16'hFFFF, 16'($urandom())};
        default: d = 64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 3));
      endcase
      do_add(d, ($urandom_range(0, 7) == 0), $urandom_range(0, 2));
    end

    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
